multi_pattern_detector: RTL
===========================

# multi_pattern_detector

Parametrised, programmable successor to the fixed two-pattern nibble detector. Watches a stream of SYM_W-bit symbols and flags every occurrence of up to NUM_PAT runtime-programmable PAT_LEN-symbol sequences. Supports per-symbol don't-care masks, overlapping matches and saturating per-pattern hit counters. Sits directly after the symbol source, in the same position as the fixed detector, and drives the pattern-event logic.

## Interface
- SYM_W, 4, symbol width in bits
- PAT_LEN, 4, symbols per pattern (≥2)
- NUM_PAT, 2, number of independent patterns (≥1)
- CNT_W, 8, width of each hit counter
- RST_PATS, {16'h0619, 16'h0531}, reset pattern values, NUM_PAT×PAT_LEN×SYM_W bits; pattern p in slice p; first-received symbol in the MS symbol of each slice
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  din is a valid symbol this cycle
- din  in  SYM_W  input symbol
- flush  in  1  synchronous restart of the symbol history
- cfg_we  in  1  write pattern/mask for cfg_idx
- cfg_idx  in  clog2(NUM_PAT) (min 1)  pattern slot to write
- cfg_pat  in  PAT_LEN×SYM_W  new pattern, first symbol in MS symbol
- cfg_mask  in  PAT_LEN  1 = don't-care for that symbol position (bit PAT_LEN-1 = first symbol)
- clear_cnt  in  1  synchronous clear of all hit counters
- match  out  NUM_PAT  one-cycle pulse per pattern on detection
- any_match  out  1  OR of match
- hit_cnt  out  NUM_PAT×CNT_W  saturating hit count per pattern, pattern p in slice p

## Operation
- History window: PAT_LEN×SYM_W shift register plus fill counter (0..PAT_LEN, saturating at PAT_LEN). On an enabled cycle the window shifts toward the MS end, din enters the LS symbol, fill increments.
- Compare: pattern p hits on an enabled cycle when fill (including the incoming symbol) reaches PAT_LEN and every unmasked position of {window shifted, din} equals pattern p. Fully masked pattern hits on every enabled cycle once fill = PAT_LEN.
- Overlap: no reset of the window after a hit; 0,0,0,0 pattern on six 0 symbols hits on symbols 4, 5, 6.
- Multiple patterns may hit on the same symbol; each asserts its own match bit.
- No state change on cycles with enable = 0; history held indefinitely.
- flush: fill := 0, window := 0. flush and enable together: flush wins, symbol discarded, no match.
- Config: cfg_we writes slot cfg_idx at the clock edge; comparisons in that same cycle use the old pattern/mask, new values take effect the next cycle. cfg_idx ≥ NUM_PAT: write ignored. Config write does not touch the window or counters.
- hit_cnt[p] increments on each hit of p; saturates at 2^CNT_W−1. clear_cnt zeroes all counters; clear_cnt coincident with a hit: clear wins, counter = 0 (match pulse still issued).
- Reset state: window 0, fill 0, patterns = RST_PATS, masks all 0, match 0, any_match 0, hit_cnt 0.

## Timing
- All outputs registered. Symbol accepted at edge N → match/any_match high during cycle N+1 for exactly one cycle (unless another hit on the next enabled symbol, giving back-to-back pulses).
- hit_cnt updates at the same edge match rises; visible in cycle N+1.
- reset_n low asynchronously forces reset state immediately, mid-sequence included; first symbol after reset_n deasserts starts a fresh window (fill 0).
- Minimum detection latency from reset: PAT_LEN enabled symbols.

## Test plan
- Defaults, stream 0,5,3,1 then 0,6,1,9 with enable=1 → match[0] pulse one cycle after symbol '1', match[1] one cycle after '9', hit_cnt = {1,1}.
- Overlap: program slot 0 = 0000 (mask 0), feed six 0 symbols → match[0] high for 3 consecutive cycles, hit_cnt[0] = 3.
- Mask: slot 1 = 0,x,x,9 (cfg_mask = 4'b0110), feed 0,A,B,9 and 0,6,1,9 → two match[1] pulses; 1,6,1,9 → none.
- Gaps/flush: 0,5, enable low 10 cycles, 3,1 → match[0]; 0,5,flush,3,1 → no match; flush+enable with '1' on the last symbol → no match.
- Saturation/clear: CNT_W=2, eight hits of slot 0 → hit_cnt[0] = 3; clear_cnt on a hit cycle → 0 with match pulse present.
- Reset mid-sequence: 0,5,3, pulse reset_n low asynchronously (between edges), then 1 → no match; outputs 0 during reset, patterns back to RST_PATS.

Source files
------------

// File: rtl/multi_pattern_detector_if.sv
// rtl/multi_pattern_detector_if.sv - symbol stream, pattern config and match outputs of the detector
interface multi_pattern_detector_if #(
  parameter int SYM_W   = 4,
  parameter int PAT_LEN = 4,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8
);
  localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

  logic                       enable;
  logic [SYM_W-1:0]           din;
  logic                       flush;
  logic                       cfg_we;
  logic [IDX_W-1:0]           cfg_idx;
  logic [PAT_LEN*SYM_W-1:0]   cfg_pat;
  logic [PAT_LEN-1:0]         cfg_mask;
  logic                       clear_cnt;
  logic [NUM_PAT-1:0]         match;
  logic                       any_match;
  logic [NUM_PAT*CNT_W-1:0]   hit_cnt;

  modport master (
    output enable, din, flush, cfg_we, cfg_idx, cfg_pat, cfg_mask, clear_cnt,
    input  match, any_match, hit_cnt
  );

  modport slave (
    input  enable, din, flush, cfg_we, cfg_idx, cfg_pat, cfg_mask, clear_cnt,
    output match, any_match, hit_cnt
  );
endinterface

// File: rtl/multi_pattern_detector.sv
// rtl/multi_pattern_detector.sv - programmable multi-pattern symbol detector
// Sliding window compared against NUM_PAT masked patterns; overlapping hits, saturating counters.
module multi_pattern_detector #(
  parameter int SYM_W   = 4,
  parameter int PAT_LEN = 4,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8,
  parameter logic [NUM_PAT*PAT_LEN*SYM_W-1:0] RST_PATS = {16'h0619, 16'h0531}
) (
  input logic                     clk,
  input logic                     reset_n,
  multi_pattern_detector_if.slave bus
);
  localparam int WIN_W  = PAT_LEN * SYM_W;
  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic [WIN_W-1:0]         window;
  logic [FILL_W-1:0]        fill;
  logic [WIN_W-1:0]         pats  [NUM_PAT];
  logic [PAT_LEN-1:0]       masks [NUM_PAT];
  logic [WIN_W-1:0]         care  [NUM_PAT];
  logic [WIN_W-1:0]         next_window;
  logic                     window_full;
  logic [NUM_PAT-1:0]       hit;
  logic [NUM_PAT-1:0]       match_q;
  logic                     any_q;
  logic [NUM_PAT*CNT_W-1:0] cnt_q;

  // Full once the incoming symbol completes PAT_LEN symbols of history.
  assign window_full = (fill >= FILL_W'(PAT_LEN - 1));

  always_comb begin
    next_window = {window[WIN_W-SYM_W-1:0], bus.din};
    hit = '0;
    for (int p = 0; p < NUM_PAT; p++) begin
      care[p] = '0;
      for (int s = 0; s < PAT_LEN; s++) begin
        care[p][s*SYM_W +: SYM_W] = {SYM_W{~masks[p][s]}};
      end
      hit[p] = bus.enable && !bus.flush && window_full &&
               (((next_window ^ pats[p]) & care[p]) == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window  <= '0;
      fill    <= '0;
      match_q <= '0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
      for (int p = 0; p < NUM_PAT; p++) begin
        pats[p]  <= RST_PATS[p*WIN_W +: WIN_W];
        masks[p] <= '0;
      end
    end else begin
      match_q <= hit;
      any_q   <= |hit;

      if (bus.flush) begin
        window <= '0;
        fill   <= '0;
      end else if (bus.enable) begin
        window <= next_window;
        if (fill != FILL_W'(PAT_LEN))
          fill <= fill + FILL_W'(1);
      end

      // Clear takes priority over a coincident hit.
      for (int p = 0; p < NUM_PAT; p++) begin
        if (bus.clear_cnt)
          cnt_q[p*CNT_W +: CNT_W] <= '0;
        else if (hit[p] && (cnt_q[p*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          cnt_q[p*CNT_W +: CNT_W] <= cnt_q[p*CNT_W +: CNT_W] + CNT_W'(1);
      end

      if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_PAT)) begin
        pats[bus.cfg_idx]  <= bus.cfg_pat;
        masks[bus.cfg_idx] <= bus.cfg_mask;
      end
    end
  end

  assign bus.match     = match_q;
  assign bus.any_match = any_q;
  assign bus.hit_cnt   = cnt_q;
endmodule
